// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU core (m0)
// and the boot loader / DMA engine (m1). One transaction is in flight at a
// time. Writes complete in the grant cycle. Reads wait RD_LAT cycles for
// slave data, then spend one DATA cycle returning it to the owner.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [W-1:0]  m0_wdata,
  input  logic [3:0]    m0_wr_mask,
  output logic [W-1:0]  m0_rdata,
  output logic          m0_rd_valid,
  output logic          m0_ack,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m1_wr_mask,
  output logic [W-1:0]  m1_rdata,
  output logic          m1_rd_valid,
  output logic          m1_ack,
  output logic          s_ren,
  output logic          s_wen,
  output logic [AW-1:0] s_addr,
  output logic [W-1:0]  s_wdata,
  output logic [3:0]    s_wr_mask,
  input  logic [W-1:0]  s_rdata,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, DATA} state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic [2:0] cnt;

  logic          m0_req;
  logic          m1_req;
  logic          grant_valid;
  logic          winner;
  logic          win_wen;
  logic          win_both;
  logic          owner_ren;
  logic          sel;
  logic          sel_valid;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_wdata;
  logic [3:0]    sel_mask;

  // Round-robin winner selection; only meaningful in IDLE and never during reset
  always_comb begin
    m0_req      = m0_ren | m0_wen;
    m1_req      = m1_ren | m1_wen;
    grant_valid = !rst && (state == IDLE) && (m0_req || m1_req);
    if (m0_req && m1_req) winner = ~last;
    else                  winner = m1_req;
    win_wen   = winner ? m1_wen : m0_wen;
    win_both  = winner ? (m1_ren & m1_wen) : (m0_ren & m0_wen);
    owner_ren = owner ? m1_ren : m0_ren;
  end

  // Slave port mux: winner in IDLE, registered owner while waiting for read data
  always_comb begin
    sel       = (state == IDLE) ? winner : owner;
    sel_valid = grant_valid || (!rst && (state == RD_WAIT));
    sel_addr  = sel ? m1_addr    : m0_addr;
    sel_wdata = sel ? m1_wdata   : m0_wdata;
    sel_mask  = sel ? m1_wr_mask : m0_wr_mask;
    s_ren     = 1'b0;
    s_wen     = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wr_mask = 4'b1111;
    if (sel_valid) begin
      s_addr    = sel_addr;
      s_wdata   = sel_wdata;
      s_wr_mask = sel_mask;
      if (state == IDLE && win_wen) s_wen = (sel_addr != '0);
      else                          s_ren = 1'b1;
    end
  end

  // Master responses: write ack in the grant cycle, read data/ack in DATA
  always_comb begin
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_rd_valid = 1'b0;
    m1_rd_valid = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    if (grant_valid && win_wen) begin
      m0_ack = ~winner;
      m1_ack = winner;
    end
    if (!rst && state == DATA) begin
      if (owner) begin
        m1_ack      = 1'b1;
        m1_rd_valid = 1'b1;
        m1_rdata    = s_rdata;
      end else begin
        m0_ack      = 1'b1;
        m0_rd_valid = 1'b1;
        m0_rdata    = s_rdata;
      end
    end
  end

  // Transaction FSM with round-robin history, latency counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last <= winner;
            if (win_both) err <= 1'b1;
            if (!win_wen) begin
              owner <= winner;
              cnt   <= 3'(RD_LAT - 1);
              state <= (RD_LAT > 1) ? RD_WAIT : DATA;
            end
          end
        end
        RD_WAIT: begin
          if (!owner_ren) err <= 1'b1;
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= DATA;
        end
        DATA: begin
          if (!owner_ren) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances share the master inputs
// and differ only in read latency (1, 3, 4); each scenario resets all of
// them and checks the instance it targets.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wr_mask, m1_wr_mask;
  logic [31:0] s_rdata;

  logic [31:0] m0_rdata [3];
  logic [31:0] m1_rdata [3];
  logic        m0_rd_valid [3];
  logic        m1_rd_valid [3];
  logic        m0_ack [3];
  logic        m1_ack [3];
  logic        s_ren [3];
  logic        s_wen [3];
  logic [15:0] s_addr [3];
  logic [31:0] s_wdata [3];
  logic [3:0]  s_wr_mask [3];
  logic        err [3];

  int vectors;
  int miscompares;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .AW(16), .W(32), .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) dut (
      .clk(clk), .rst(rst),
      .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wr_mask(m0_wr_mask),
      .m0_rdata(m0_rdata[g]), .m0_rd_valid(m0_rd_valid[g]), .m0_ack(m0_ack[g]),
      .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wr_mask(m1_wr_mask),
      .m1_rdata(m1_rdata[g]), .m1_rd_valid(m1_rd_valid[g]), .m1_ack(m1_ack[g]),
      .s_ren(s_ren[g]), .s_wen(s_wen[g]), .s_addr(s_addr[g]),
      .s_wdata(s_wdata[g]), .s_wr_mask(s_wr_mask[g]),
      .s_rdata(s_rdata), .err(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive both master request buses in one call
  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                               input logic r1, input logic w1, input logic [15:0] a1);
    m0_ren = r0; m0_wen = w0; m0_addr = a0;
    m1_ren = r1; m1_wen = w1; m1_addr = a1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    m0_wdata    = 32'h1111_1111;
    m1_wdata    = 32'h2222_2222;
    m0_wr_mask  = 4'b1111;
    m1_wr_mask  = 4'b0011;
    s_rdata     = 32'hDEAD_BEEF;

    // Reset state, with a request pending that must not leak through
    applyStimulus(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("rst_s_ren", 32'(s_ren[0]), 32'd0);
    checkOutput("rst_s_wr_mask", 32'(s_wr_mask[0]), 32'hF);
    checkOutput("rst_m0_ack", 32'(m0_ack[0]), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata[0], 32'd0);
    checkOutput("rst_err", 32'(err[0]), 32'd0);

    // 1: m0 read, RD_LAT=1
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t1_c0_s_ren", 32'(s_ren[0]), 32'd1);
    checkOutput("t1_c0_s_addr", 32'(s_addr[0]), 32'h0010);
    checkOutput("t1_c0_m0_ack", 32'(m0_ack[0]), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_c1_rd_valid", 32'(m0_rd_valid[0]), 32'd1);
    checkOutput("t1_c1_ack", 32'(m0_ack[0]), 32'd1);
    checkOutput("t1_c1_rdata", m0_rdata[0], 32'hDEAD_BEEF);
    checkOutput("t1_c1_s_ren", 32'(s_ren[0]), 32'd0);
    checkOutput("t1_c1_m1_ack", 32'(m1_ack[0]), 32'd0);
    checkOutput("t1_c1_m1_rd_valid", 32'(m1_rd_valid[0]), 32'd0);
    checkOutput("t1_c1_m1_rdata", m1_rdata[0], 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t1_c2_rdata", m0_rdata[0], 32'd0);
    checkOutput("t1_c2_ack", 32'(m0_ack[0]), 32'd0);
    checkOutput("t1_c2_err", 32'(err[0]), 32'd0);

    // 2: both masters write continuously; grants alternate m0, m1
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0200);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_c%0d_s_addr", k), 32'(s_addr[0]),
                  (k % 2 == 0) ? 32'h0100 : 32'h0200);
      checkOutput($sformatf("t2_c%0d_s_wdata", k), s_wdata[0],
                  (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
      checkOutput($sformatf("t2_c%0d_s_wen", k), 32'(s_wen[0]), 32'd1);
      checkOutput($sformatf("t2_c%0d_m0_ack", k), 32'(m0_ack[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_c%0d_m1_ack", k), 32'(m1_ack[0]), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end

    // 3: RD_LAT=3; after an m0 grant, m1 read beats a pending m0 write
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t3_pre_m0_ack", 32'(m0_ack[1]), 32'd1);
    tick();
    s_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b0, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0040);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_w%0d_s_ren", k), 32'(s_ren[1]), 32'd1);
      checkOutput($sformatf("t3_w%0d_s_addr", k), 32'(s_addr[1]), 32'h0040);
      checkOutput($sformatf("t3_w%0d_s_wen", k), 32'(s_wen[1]), 32'd0);
      checkOutput($sformatf("t3_w%0d_m0_ack", k), 32'(m0_ack[1]), 32'd0);
      checkOutput($sformatf("t3_w%0d_m1_ack", k), 32'(m1_ack[1]), 32'd0);
      tick();
    end
    @(negedge clk);
    checkOutput("t3_data_s_ren", 32'(s_ren[1]), 32'd0);
    checkOutput("t3_data_m1_rd_valid", 32'(m1_rd_valid[1]), 32'd1);
    checkOutput("t3_data_m1_ack", 32'(m1_ack[1]), 32'd1);
    checkOutput("t3_data_m1_rdata", m1_rdata[1], 32'hCAFE_F00D);
    checkOutput("t3_data_m0_ack", 32'(m0_ack[1]), 32'd0);
    checkOutput("t3_data_m0_rdata", m0_rdata[1], 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t3_wr_s_wen", 32'(s_wen[1]), 32'd1);
    checkOutput("t3_wr_s_addr", 32'(s_addr[1]), 32'h0080);
    checkOutput("t3_wr_m0_ack", 32'(m0_ack[1]), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t3_err", 32'(err[1]), 32'd0);

    // 4: write to address 0 is acked but not forwarded
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t4_m0_ack", 32'(m0_ack[0]), 32'd1);
    checkOutput("t4_s_wen", 32'(s_wen[0]), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t4_err", 32'(err[0]), 32'd0);

    // 5: ren and wen together on m1 becomes a write and sets sticky err
    doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020);
    @(negedge clk);
    checkOutput("t5_s_wen", 32'(s_wen[0]), 32'd1);
    checkOutput("t5_s_ren", 32'(s_ren[0]), 32'd0);
    checkOutput("t5_s_addr", 32'(s_addr[0]), 32'h0020);
    checkOutput("t5_s_wr_mask", 32'(s_wr_mask[0]), 32'h3);
    checkOutput("t5_m1_ack", 32'(m1_ack[0]), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t5_err_set", 32'(err[0]), 32'd1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("t5_err_sticky", 32'(err[0]), 32'd1);
    checkOutput("t5_no_read", 32'(m1_rd_valid[0]), 32'd0);
    doReset();
    @(negedge clk);
    checkOutput("t5_err_cleared", 32'(err[0]), 32'd0);

    // 6: reset in RD_WAIT (RD_LAT=4, cnt=2) discards the read; m0 wins after release
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t6_c0_s_ren", 32'(s_ren[2]), 32'd1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("t6_c2_s_ren", 32'(s_ren[2]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_s_ren", 32'(s_ren[2]), 32'd0);
    checkOutput("t6_async_s_addr", 32'(s_addr[2]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("t6_r%0d_rd_valid", k), 32'(m0_rd_valid[2]), 32'd0);
      checkOutput($sformatf("t6_r%0d_ack", k), 32'(m0_ack[2]), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0030, 1'b1, 1'b0, 16'h0050);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_post_s_ren", 32'(s_ren[2]), 32'd1);
    checkOutput("t6_post_s_addr", 32'(s_addr[2]), 32'h0030);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
